// File: rtl/spm_mult_seq.sv
// Sequential serial-parallel multiplier: WIDTH carry-save cells, y streamed LSB-first, 2*WIDTH-bit result.
// Optional serial product output (p_bit/p_bit_valid) enabled by defining SPM_SERIAL_OUT_EN.
module spm_mult_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(2*WIDTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_signed,
   input  logic [WIDTH-1:0]     in_x,
   input  logic [WIDTH-1:0]     in_y,
   output logic                 out_valid,
   input  logic                 out_ready,
`ifdef SPM_SERIAL_OUT_EN
   output logic                 p_bit,
   output logic                 p_bit_valid,
`endif
   output logic [2*WIDTH-1:0]   out_p
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     x_q, x_d;
   logic [WIDTH-1:0]     y_q, y_d;
   logic                 sgn_q, sgn_d;
   logic [WIDTH-1:0]     hsum_q, hsum_d;
   logic [WIDTH-1:0]     hcarry_q, hcarry_d;
   logic [2*WIDTH-1:0]   out_p_q, out_p_d;

   logic [WIDTH-1:0]     pp, fa_sum, fa_carry, hsum_shift;

   // Signed mode: the MSB cell adds ~(x[W-1]&y_bit) instead of subtracting x[W-1]&y_bit;
   // the accumulated -1 constants reduce to +2^(W-1) mod 2^(2W), seeded at accept.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         pp[i]       = x_q[i] & y_q[0];
         if (i == WIDTH-1) pp[i] = pp[i] ^ sgn_q;
         fa_sum[i]   = hsum_q[i] ^ hcarry_q[i] ^ pp[i];
         fa_carry[i] = (hsum_q[i] & hcarry_q[i]) | (hsum_q[i] & pp[i]) | (hcarry_q[i] & pp[i]);
      end
      hsum_shift = {1'b0, fa_sum[WIDTH-1:1]};
   end

   // NOTE: every signal written here gets its default first so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      x_d      = x_q;
      y_d      = y_q;
      sgn_d    = sgn_q;
      hsum_d   = hsum_q;
      hcarry_d = hcarry_q;
      out_p_d  = out_p_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               x_d      = in_x;
               y_d      = in_y;
               sgn_d    = in_signed;
               hcarry_d = '0;
               hsum_d   = in_signed ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
               cnt_d    = '0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            hsum_d   = hsum_shift;
            hcarry_d = fa_carry;
            y_d      = {sgn_q & y_q[WIDTH-1], y_q[WIDTH-1:1]};
            cnt_d    = cnt_q + 1'b1;
            out_p_d[cnt_q[CNT_W-2:0]] = fa_sum[0];
            if (cnt_q == CNT_W'(2*WIDTH-1)) state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d  = S_IDLE;
         cnt_d    = '0;
         hsum_d   = '0;
         hcarry_d = '0;
         out_p_d  = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         sgn_q    <= 1'b0;
         hsum_q   <= '0;
         hcarry_q <= '0;
         out_p_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         x_q      <= x_d;
         y_q      <= y_d;
         sgn_q    <= sgn_d;
         hsum_q   <= hsum_d;
         hcarry_q <= hcarry_d;
         out_p_q  <= out_p_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out_p     = out_p_q;

`ifdef SPM_SERIAL_OUT_EN
   logic p_bit_q, p_bit_d, p_bit_valid_q, p_bit_valid_d;

   // Bit k leaves the chain in RUN cycle k and is presented one cycle later.
   always_comb begin
      p_bit_d       = fa_sum[0];
      p_bit_valid_d = (state_q == S_RUN) && !flush;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_bit_q       <= 1'b0;
         p_bit_valid_q <= 1'b0;
      end else begin
         p_bit_q       <= p_bit_d;
         p_bit_valid_q <= p_bit_valid_d;
      end
   end

   assign p_bit       = p_bit_q;
   assign p_bit_valid = p_bit_valid_q;
`endif

endmodule

// File: tb/tb_spm_mult_seq.sv
// Directed bench for spm_mult_seq at WIDTH=8: latency, products, backpressure, flush and reset.
// Serial-output checks are compiled in when SPM_SERIAL_OUT_EN is defined.
module tb_spm_mult_seq;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst, flush, in_valid, in_signed, out_ready;
   logic [W-1:0]   in_x, in_y;
   logic           in_ready, out_valid;
   logic [2*W-1:0] out_p;
`ifdef SPM_SERIAL_OUT_EN
   logic           p_bit, p_bit_valid;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   spm_mult_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
      .in_x(in_x), .in_y(in_y),
      .out_valid(out_valid), .out_ready(out_ready),
`ifdef SPM_SERIAL_OUT_EN
      .p_bit(p_bit), .p_bit_valid(p_bit_valid),
`endif
      .out_p(out_p)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Advance one cycle; outputs are sampled at the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_checks(input string tag, input logic [2*W-1:0] exp_p);
      check({tag, " in_ready"}, 64'(in_ready), 64'd1);
      check({tag, " out_valid"}, 64'(out_valid), 64'd0);
      check({tag, " out_p"}, 64'(out_p), 64'(exp_p));
`ifdef SPM_SERIAL_OUT_EN
      check({tag, " p_bit_valid"}, 64'(p_bit_valid), 64'd0);
`endif
   endtask

   // Accept at cycle T, verify busy window T+1..T+2W, then result at T+2W+1.
   task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic sgn, input logic [2*W-1:0] exp, input bit release_out);
      int bad = 0;
`ifdef SPM_SERIAL_OUT_EN
      logic [2*W-1:0] ser = '0;
      int nser = 0;
`endif
      in_x = x; in_y = y; in_signed = sgn; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; in_x = '0; in_y = '0; in_signed = 1'b0;
      for (int c = 1; c <= 2*W+1; c++) begin
         if (in_ready !== 1'b0) bad++;
         if (c <= 2*W && out_valid !== 1'b0) bad++;
`ifdef SPM_SERIAL_OUT_EN
         if (p_bit_valid !== (c >= 2)) bad++;
         if (p_bit_valid === 1'b1 && nser < 2*W) begin
            ser[nser] = p_bit;
            nser++;
         end
`endif
         if (c < 2*W+1) tick();
      end
      check({tag, " busy-window errors"}, 64'(bad), 64'd0);
      check({tag, " out_valid"}, 64'(out_valid), 64'd1);
      check({tag, " out_p"}, 64'(out_p), 64'(exp));
`ifdef SPM_SERIAL_OUT_EN
      check({tag, " serial count"}, 64'(nser), 64'(2*W));
      check({tag, " serial bits"}, 64'(ser), 64'(exp));
`endif
      if (release_out) begin
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         idle_checks({tag, " after release"}, exp);
      end
   endtask

   initial begin
      int bad;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
      out_ready = 1'b0; in_x = '0; in_y = '0;
      tick();
      tick();
      rst = 1'b0;
      idle_checks("reset", '0);

      // Backpressure: result held for 10 cycles, then released.
      run_op("u 0f*11", 8'h0F, 8'h11, 1'b0, 16'h00FF, 1'b0);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_valid !== 1'b1 || out_p !== 16'h00FF || in_ready !== 1'b0) bad++;
      end
      check("backpressure hold errors", 64'(bad), 64'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      idle_checks("backpressure release", 16'h00FF);

      run_op("u ff*ff",  8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);
      run_op("s ff*ff",  8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b1);
      run_op("s 80*80",  8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
      run_op("s 80*01",  8'h80, 8'h01, 1'b1, 16'hFF80, 1'b1);

      // Flush in RUN cycle 5 with a competing in_valid that must be ignored.
      in_x = 8'hAA; in_y = 8'h55; in_signed = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      flush = 1'b1; in_valid = 1'b1; in_x = 8'h77; in_y = 8'h33;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      idle_checks("flush", '0);
      bad = 0;
      for (int i = 0; i < 2*W+4; i++) begin
         tick();
         if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
      end
      check("flushed op stays silent", 64'(bad), 64'd0);
      run_op("u 03*05 after flush", 8'h03, 8'h05, 1'b0, 16'h000F, 1'b1);

      // Reset in the middle of RUN.
      in_x = 8'hC3; in_y = 8'h5A; in_signed = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle_checks("rst mid-run", '0);

      // Reset while holding a result in DONE.
      run_op("s fd*07", 8'hFD, 8'h07, 1'b1, 16'hFFEB, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle_checks("rst in done", '0);

      run_op("u a5*3c", 8'hA5, 8'h3C, 1'b0, 16'h26AC, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/spm_mult_seq.md
Name: spm_mult_seq

Overview:
- Parametrised sequential serial-parallel multiplier, successor to the fixed 32-bit spm array.
- Holds a WIDTH-bit parallel operand x; the operand y is loaded internally and shifted in LSB-first through a chain of WIDTH carry-save cells (hsum/hcarry registers per cell).
- Adds a valid/ready handshake, an unsigned/signed mode, a flush, and a parallel 2*WIDTH-bit result register.
- Sits between the operand-issue logic and the product consumer.

Parameters:
- WIDTH, 32, operand width in bits (legal range 4..64); product width is 2*WIDTH.
- CNT_W, $clog2(2*WIDTH)+1, bit counter width (derived; do not override).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- flush  input  1  synchronous abort of any operation in progress
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- in_signed  input  1  1 = two's-complement x and y, 0 = unsigned; sampled at accept
- in_x  input  WIDTH  parallel operand
- in_y  input  WIDTH  serial operand, loaded into the internal shift register
- out_valid  output  1  product available
- out_ready  input  1  consumer accepts product
- out_p  output  2*WIDTH  product, modulo 2^(2*WIDTH)

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; counter=0; all CSA sum/carry registers, x/y registers and out_p cleared to 0.
  - in_ready=1 from the first cycle after reset; out_valid=0.
- Priority: rst > flush > normal operation.
- flush=1 in any state:
  - next state IDLE; CSA registers and counter cleared; out_valid=0; out_p cleared.
  - An in_valid asserted in the same cycle is not accepted.
- FSM:
  - IDLE: in_ready=1. If in_valid=1 (cycle T), latch in_x, in_y and in_signed; clear the CSA chain; go to RUN with counter=0.
  - RUN: in_ready=0. Each cycle one y bit enters the chain and counter increments. Bits 0..WIDTH-1 are y[0..WIDTH-1]. Bits WIDTH..2*WIDTH-1 are y[WIDTH-1] in signed mode and 0 in unsigned mode.
  - RUN lasts exactly 2*WIDTH cycles (T+1..T+2*WIDTH). Product bit k is captured into out_p[k] at the end of RUN cycle k.
  - DONE: entered at cycle T+2*WIDTH+1. out_valid=1 and out_p is stable. Stay in DONE while out_ready=0; on out_ready=1 go to IDLE next cycle.
- Back-to-back: in_ready stays 0 in DONE, so a new accept occurs no earlier than the cycle after the output handshake. Minimum initiation interval is 2*WIDTH+2 cycles.
- Signed mode:
  - The MSB cell treats x[WIDTH-1] as having weight -2^(WIDTH-1) (two's-complement correction cell).
  - out_p = sign-extended x * sign-extended y, truncated to 2*WIDTH bits.
- Unsigned mode: out_p = x*y exactly; no overflow is possible.
- Inputs other than in_valid are don't-care outside the accept cycle.
- out_p holds its last value in IDLE; it is cleared only by rst or flush.
- Reset or flush during RUN discards the partial product; no out_valid is ever generated for that operation.

Optional Feature:
- Macro: SPM_SERIAL_OUT_EN
- When defined, adds two outputs:
  - p_bit (1): product bit k, driven in cycle T+2+k for k=0..2*WIDTH-1.
  - p_bit_valid (1): high exactly in those 2*WIDTH cycles, low in all other cycles and after rst/flush.
- The last serial bit (k=2*WIDTH-1) coincides with the first cycle of out_valid.
- When not defined, neither port exists and behaviour is otherwise identical.

Test Plan:
- WIDTH=8, unsigned, x=0x0F, y=0x11 -> out_valid at T+17, out_p=0x00FF; in_ready low T+1..T+17.
- WIDTH=8, unsigned, x=0xFF, y=0xFF -> out_p=0xFE01. Signed, same operands -> out_p=0x0001.
- WIDTH=8, signed, x=0x80, y=0x80 -> out_p=0x4000. Signed, x=0x80, y=0x01 -> out_p=0xFF80.
- Backpressure: out_ready held 0 for 10 cycles after out_valid -> out_valid and out_p=0x00FF stable throughout, in_ready=0; release -> IDLE and in_ready=1 the next cycle.
- flush at RUN cycle 5, then new op x=0x03, y=0x05 -> first op never produces out_valid; out_p=0x000F at its own T+17.
- rst asserted mid-RUN and in DONE -> next cycle out_valid=0, out_p=0, in_ready=1. With SPM_SERIAL_OUT_EN defined, p_bit_valid=0 at the same point, and a normal op emits p_bit sequence equal to out_p LSB-first.
